if_unit: RTL and testbench

- Instruction fetch stage: the producer end of the 32-bit instruction word that the decoder consumes.
- Generates the PC, runs a single-outstanding request/ack read on the instruction port, and presents instruction, pc and valid to decode.
- Handles decode stalls through a 1-entry skid buffer.
- Handles branch/jump redirects, discarding in-flight fetches, and fetch exceptions.

---
 rtl/if_unit.sv | 159 +++++++++++++++
 tb/tb_if_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_unit.sv
// Instruction fetch stage: PC generation, single-outstanding request/ack fetch,
// 1-entry skid buffer towards decode, redirect handling and fetch exceptions.
module if_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] iport_addr,
  output logic        iport_cyc,
  output logic        iport_stb,
  input  logic [31:0] iport_data_i,
  input  logic        iport_ack,
  input  logic        iport_err,
  input  logic        id_stall,
  input  logic        pc_redirect,
  input  logic [31:0] pc_target,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        if_exception,
  output logic [1:0]  if_exc_cause
);

  typedef enum logic [1:0] {FETCH, DISCARD, HALT} state_t;

  state_t      state;
  logic [31:0] pc;

  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        skid_exc;
  logic [1:0]  skid_cause;

  logic        accept;
  logic        bus_ack;
  logic        bus_err;
  logic        bus_done;
  logic        fetch_rsp;
  logic        target_misaligned;
  logic [31:0] rsp_instr;
  logic [1:0]  rsp_cause;
  logic [31:0] pc_inc;
  logic        skid_full_next;
  logic        issue_next;

  assign accept            = !if_valid || !id_stall;
  assign bus_err           = iport_stb && iport_err;
  assign bus_ack           = iport_stb && iport_ack && !iport_err;
  assign bus_done          = bus_ack || bus_err;
  assign fetch_rsp         = (state == FETCH) && bus_done;
  assign target_misaligned = |pc_target[1:0];
  assign rsp_instr         = bus_err ? NOP_INSN : iport_data_i;
  assign rsp_cause         = bus_err ? 2'd1 : 2'd0;
  assign pc_inc            = pc + 32'd4;

  // A new request may go out only if the skid will be empty after this edge;
  // a completing ack lets the next request follow without a bubble.
  assign skid_full_next = skid_valid ? !accept : (fetch_rsp && !accept);
  assign issue_next     = !bus_err && !skid_full_next && (!iport_stb || bus_ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FETCH;
      pc             <= RESET_ADDR;
      iport_addr     <= RESET_ADDR;
      iport_cyc      <= 1'b0;
      iport_stb      <= 1'b0;
      if_instruction <= NOP_INSN;
      if_pc          <= RESET_ADDR;
      if_valid       <= 1'b0;
      if_exception   <= 1'b0;
      if_exc_cause   <= 2'd0;
      skid_valid     <= 1'b0;
      skid_instr     <= NOP_INSN;
      skid_pc        <= RESET_ADDR;
      skid_exc       <= 1'b0;
      skid_cause     <= 2'd0;
    end else if (pc_redirect) begin
      pc             <= pc_target;
      skid_valid     <= 1'b0;
      if_instruction <= NOP_INSN;
      if_pc          <= pc_target;
      if_valid       <= target_misaligned;
      if_exception   <= target_misaligned;
      if_exc_cause   <= 2'd0;
      // An open request keeps the bus until it responds; its data is dropped.
      if (iport_stb && !bus_done) begin
        state <= target_misaligned ? HALT : DISCARD;
      end else begin
        iport_cyc <= 1'b0;
        iport_stb <= 1'b0;
        state     <= target_misaligned ? HALT : FETCH;
      end
    end else begin
      if (accept) begin
        if (skid_valid) begin
          if_instruction <= skid_instr;
          if_pc          <= skid_pc;
          if_valid       <= 1'b1;
          if_exception   <= skid_exc;
          if_exc_cause   <= skid_cause;
          skid_valid     <= 1'b0;
        end else if (fetch_rsp) begin
          if_instruction <= rsp_instr;
          if_pc          <= iport_addr;
          if_valid       <= 1'b1;
          if_exception   <= bus_err;
          if_exc_cause   <= rsp_cause;
        end else begin
          if_instruction <= NOP_INSN;
          if_valid       <= 1'b0;
          if_exception   <= 1'b0;
        end
      end else if (fetch_rsp) begin
        skid_instr <= rsp_instr;
        skid_pc    <= iport_addr;
        skid_exc   <= bus_err;
        skid_cause <= rsp_cause;
        skid_valid <= 1'b1;
      end

      case (state)
        FETCH: begin
          if (bus_ack) pc <= pc_inc;
          if (bus_err) begin
            state     <= HALT;
            iport_cyc <= 1'b0;
            iport_stb <= 1'b0;
          end else if (issue_next) begin
            iport_cyc  <= 1'b1;
            iport_stb  <= 1'b1;
            iport_addr <= bus_ack ? pc_inc : pc;
          end else if (bus_ack) begin
            iport_cyc <= 1'b0;
            iport_stb <= 1'b0;
          end
        end
        DISCARD: begin
          if (bus_done) begin
            state      <= FETCH;
            iport_cyc  <= 1'b1;
            iport_stb  <= 1'b1;
            iport_addr <= pc;
          end
        end
        HALT: begin
          if (bus_done) begin
            iport_cyc <= 1'b0;
            iport_stb <= 1'b0;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_unit.sv
// Bench for if_unit: directed vector table, hand-written corner sequences and a
// randomized run checked against a program-order stream model.
module tb_if_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] iport_addr;
  logic        iport_cyc;
  logic        iport_stb;
  logic [31:0] iport_data_i;
  logic        iport_ack;
  logic        iport_err;
  logic        id_stall = 1'b0;
  logic        pc_redirect = 1'b0;
  logic [31:0] pc_target = '0;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        if_exception;
  logic [1:0]  if_exc_cause;

  int n_cmp = 0;
  int n_bad = 0;

  if_unit #(.RESET_ADDR(32'h0000_0000), .NOP_INSN(NOP)) dut (
    .clk(clk), .rst(rst),
    .iport_addr(iport_addr), .iport_cyc(iport_cyc), .iport_stb(iport_stb),
    .iport_data_i(iport_data_i), .iport_ack(iport_ack), .iport_err(iport_err),
    .id_stall(id_stall), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .if_instruction(if_instruction), .if_pc(if_pc), .if_valid(if_valid),
    .if_exception(if_exception), .if_exc_cause(if_exc_cause)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit hash_err(input logic [31:0] a);
    return ((a >> 2) % 29) == 13;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: latency counted in cycles from the first cycle stb is seen.
  int          lat_max = 0;
  bit          lat_rand = 0;
  bit          rand_err = 0;
  bit          late_ack = 0;
  logic [31:0] err_addr = '1;
  bit          started = 0;
  int          rem = 0;

  always @(negedge clk) begin
    iport_ack    = late_ack;
    iport_err    = 1'b0;
    iport_data_i = 32'hDEAD_BEEF;
    if (iport_stb === 1'b1) begin
      if (!started) begin
        started = 1;
        rem = lat_rand ? int'($urandom_range(0, lat_max)) : lat_max;
      end
      if (rem == 0) begin
        started = 0;
        if (iport_addr == err_addr || (rand_err && hash_err(iport_addr))) begin
          iport_err = 1'b1;
          iport_ack = 1'($urandom_range(0, 1));
        end else begin
          iport_ack    = 1'b1;
          iport_data_i = mem_word(iport_addr);
        end
      end else begin
        rem--;
      end
    end else begin
      started = 0;
    end
  end

  task automatic step(input bit r, input bit stall, input bit redir, input logic [31:0] tgt);
    @(negedge clk); #1;
    rst = r; id_stall = stall; pc_redirect = redir; pc_target = tgt;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          rst;
    bit          stall;
    bit          cyc;
    bit          stb;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t tbl[8];

  // Random-phase model state
  logic [31:0] exp_pc;
  bit          halted;
  bit          found;
  int          idle;
  bit          prev_open, hold_prev, last_redir;
  logic [31:0] prev_addr, sv_instr, sv_pc;
  bit          sv_valid, sv_exc;
  logic [1:0]  sv_cause;

  initial begin
    tbl[0] = '{1, 0, 0, 0, 32'h0,  0, 32'h0, NOP};
    tbl[1] = '{0, 0, 1, 1, 32'h0,  0, 32'h0, NOP};
    tbl[2] = '{0, 0, 1, 1, 32'h4,  1, 32'h0, 32'h0050_0093};
    tbl[3] = '{0, 0, 1, 1, 32'h8,  1, 32'h4, 32'h00A0_0113};
    tbl[4] = '{0, 1, 0, 0, 32'h0,  1, 32'h4, 32'h00A0_0113};
    tbl[5] = '{0, 1, 0, 0, 32'h0,  1, 32'h4, 32'h00A0_0113};
    tbl[6] = '{0, 0, 1, 1, 32'hC,  1, 32'h8, mem_word(32'h8)};
    tbl[7] = '{0, 0, 1, 1, 32'h10, 1, 32'hC, mem_word(32'hC)};

    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].rst, tbl[i].stall, 1'b0, 32'h0);
      check32($sformatf("v%0d_cyc", i), 32'(iport_cyc), 32'(tbl[i].cyc));
      check32($sformatf("v%0d_stb", i), 32'(iport_stb), 32'(tbl[i].stb));
      if (tbl[i].stb || tbl[i].rst)
        check32($sformatf("v%0d_addr", i), iport_addr, tbl[i].addr);
      check32($sformatf("v%0d_valid", i), 32'(if_valid), 32'(tbl[i].valid));
      check32($sformatf("v%0d_pc", i), if_pc, tbl[i].pc);
      check32($sformatf("v%0d_instr", i), if_instruction, tbl[i].instr);
      if (i == 0) begin
        check32("rst_exc", 32'(if_exception), 32'h0);
        check32("rst_cause", 32'(if_exc_cause), 32'h0);
      end
    end

    // Redirect while request to 0x10 is open with a slow response
    lat_max = 3;
    step(0, 0, 1, 32'h100);
    check32("disc_valid0", 32'(if_valid), 32'h0);
    check32("disc_stb", 32'(iport_stb), 32'h1);
    check32("disc_addr", iport_addr, 32'h10);
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      step(0, 0, 0, 32'h0);
      check32("disc_valid", 32'(if_valid), 32'h0);
      if (iport_stb && iport_addr != 32'h10) found = 1;
    end
    check32("redir_addr", iport_addr, 32'h100);
    lat_max = 0;
    step(0, 0, 0, 32'h0);
    check32("redir_pc", if_pc, 32'h100);
    check32("redir_instr", if_instruction, mem_word(32'h100));

    // Misaligned redirect coinciding with an ack
    step(0, 0, 1, 32'h102);
    check32("mis_valid", 32'(if_valid), 32'h1);
    check32("mis_exc", 32'(if_exception), 32'h1);
    check32("mis_cause", 32'(if_exc_cause), 32'h0);
    check32("mis_pc", if_pc, 32'h102);
    check32("mis_instr", if_instruction, NOP);
    check32("mis_stb", 32'(iport_stb), 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 32'h0);
      check32("halt_stb", 32'(iport_stb), 32'h0);
      check32("halt_valid", 32'(if_valid), 32'h0);
    end
    step(0, 0, 1, 32'h200);
    step(0, 0, 0, 32'h0);
    check32("resume_stb", 32'(iport_stb), 32'h1);
    check32("resume_addr", iport_addr, 32'h200);
    step(0, 0, 0, 32'h0);
    check32("resume_pc", if_pc, 32'h200);

    // Access fault on 0x40
    err_addr = 32'h40;
    step(0, 0, 1, 32'h38);
    exp_pc = 32'h38;
    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      step(0, 0, 0, 32'h0);
      if (if_valid && if_exception) found = 1;
      else if (if_valid) begin
        check32("err_seq_pc", if_pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
    end
    check32("err_found", 32'(found), 32'h1);
    check32("err_cause", 32'(if_exc_cause), 32'h1);
    check32("err_pc", if_pc, 32'h40);
    check32("err_instr", if_instruction, NOP);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 32'h0);
      check32("err_halt_stb", 32'(iport_stb), 32'h0);
    end
    err_addr = '1;

    // PC wraps modulo 2^32
    step(0, 0, 1, 32'hFFFF_FFFC);
    found = 0;
    for (int k = 0; k < 6 && !found; k++) begin
      step(0, 0, 0, 32'h0);
      if (if_valid) found = 1;
    end
    check32("wrap_pc0", if_pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 32'h0);
    check32("wrap_pc1", if_pc, 32'h0);
    check32("wrap_instr", if_instruction, 32'h0050_0093);

    // Reset in the middle of an open request, stale ack afterwards
    lat_max = 2;
    step(0, 0, 1, 32'h80);
    step(0, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    check32("rstmid_cyc", 32'(iport_cyc), 32'h0);
    check32("rstmid_stb", 32'(iport_stb), 32'h0);
    check32("rstmid_valid", 32'(if_valid), 32'h0);
    lat_max = 0;
    late_ack = 1;
    step(0, 0, 0, 32'h0);
    late_ack = 0;
    check32("rstmid_restart", iport_addr, 32'h0);
    check32("rstmid_stb2", 32'(iport_stb), 32'h1);
    check32("rstmid_valid2", 32'(if_valid), 32'h0);
    step(0, 0, 0, 32'h0);
    check32("rstmid_pc", if_pc, 32'h0);
    check32("rstmid_instr", if_instruction, 32'h0050_0093);

    // Randomized run against a program-order stream model
    lat_rand = 1; lat_max = 3; rand_err = 1;
    exp_pc = 32'h0; halted = 0; idle = 0;
    prev_open = 0; hold_prev = 0; last_redir = 0;
    for (int c = 0; c < 4000; c++) begin
      bit stall, redir, mis, errx;
      logic [31:0] tgt;
      @(negedge clk); #1;
      if (prev_open) begin
        check32("bus_hold_stb", 32'(iport_stb), 32'h1);
        check32("bus_hold_addr", iport_addr, prev_addr);
      end
      if (halted) begin
        check32("halt_newreq", 32'(iport_stb && !prev_open), 32'h0);
        check32("halt_valid_r", 32'(if_valid), 32'h0);
      end
      if (hold_prev) begin
        check32("stall_valid", 32'(if_valid), 32'(sv_valid));
        check32("stall_pc", if_pc, sv_pc);
        check32("stall_instr", if_instruction, sv_instr);
        check32("stall_exc", 32'(if_exception), 32'(sv_exc));
        check32("stall_cause", 32'(if_exc_cause), 32'(sv_cause));
      end
      stall = ($urandom_range(0, 99) < 30);
      redir = !last_redir && ($urandom_range(0, 99) < (halted ? 25 : 3));
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      if ($urandom_range(0, 4) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      if (if_valid && !halted && !stall && !redir) begin
        mis  = |exp_pc[1:0];
        errx = !mis && hash_err(exp_pc);
        check32("entry_pc", if_pc, exp_pc);
        check32("entry_exc", 32'(if_exception), 32'(mis || errx));
        check32("entry_instr", if_instruction, (mis || errx) ? NOP : mem_word(exp_pc));
        if (mis || errx) begin
          check32("entry_cause", 32'(if_exc_cause), mis ? 32'h0 : 32'h1);
          halted = 1;
        end
        exp_pc = exp_pc + 32'd4;
        idle = 0;
      end
      if (redir) begin
        exp_pc = tgt;
        halted = 0;
        idle = 0;
      end
      idle++;
      if (!halted && idle > 60) begin
        n_cmp++; n_bad++;
        $display("FAIL progress: no entry consumed for %0d cycles, expected pc %h", idle, exp_pc);
        idle = 0;
      end
      prev_open  = iport_stb && !(iport_ack || iport_err);
      prev_addr  = iport_addr;
      hold_prev  = if_valid && stall && !redir;
      sv_valid = if_valid; sv_pc = if_pc; sv_instr = if_instruction;
      sv_exc = if_exception; sv_cause = if_exc_cause;
      last_redir = redir;
      id_stall = stall; pc_redirect = redir; pc_target = tgt;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
